counter_access_arbiter: RTL and testbench

COUNTER_ACCESS_ARBITER -- requirements
Module: counter_access_arbiter

---
 rtl/counter_access_arbiter_pkg.sv | 39 +++
 rtl/counter_access_arbiter_rr_arbiter3.sv | 37 +++
 rtl/counter_access_arbiter.sv | 106 ++++++++++
 tb/tb_counter_access_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/counter_access_arbiter_pkg.sv
// Shared encodings for the counter access arbiter: command codes, FSM states
// and small index helpers for the three-requester round robin.
package counter_access_arbiter_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_UP   = 2'b01,
    CMD_DOWN = 2'b10,
    CMD_LOAD = 2'b11
  } cmd_e;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  function automatic logic [1:0] oh_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    if (oh[2]) begin
      idx = 2'd2;
    end else if (oh[1]) begin
      idx = 2'd1;
    end else begin
      idx = 2'd0;
    end
    return idx;
  endfunction

  function automatic logic [1:0] next_ptr(input logic [1:0] idx);
    logic [1:0] nxt;
    if (idx == 2'd2) begin
      nxt = 2'd0;
    end else begin
      nxt = idx + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/counter_access_arbiter_rr_arbiter3.sv
// Combinational three-way round-robin picker: first set request at or above
// the pointer, wrapping, returned one-hot.
module rr_arbiter3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic       valid
);

  // Search order rotates with the pointer
  always_comb begin
    gnt = 3'b000;
    case (ptr)
      2'd1: begin
        if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else gnt = 3'b000;
      end
      2'd2: begin
        if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else gnt = 3'b000;
      end
      default: begin
        if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else gnt = 3'b000;
      end
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/counter_access_arbiter.sv
// Saturating shared counter: three requesters arbitrated round-robin, one
// granted command (NOP/UP/DOWN/LOAD) executed every two cycles.
module counter_access_arbiter
  import counter_access_arbiter_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int N_REQ = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [2*N_REQ-1:0]     CMD,
  input  logic [WIDTH*N_REQ-1:0] LD_VAL,
  output logic [N_REQ-1:0]       GNT,
  output logic                   REJ,
  output logic [WIDTH-1:0]       Counter,
  output logic                   High,
  output logic                   Low
);

  state_e           state, state_nxt;
  logic [1:0]       ptr;
  logic [2:0]       win;
  logic             win_valid;
  logic [2:0]       sel_oh;
  logic [1:0]       sel_idx;
  cmd_e             sel_cmd;
  logic [WIDTH-1:0] sel_val;
  logic             blocked;
  logic [WIDTH-1:0] counter_nxt;

  rr_arbiter3 u_rr (
    .req   (REQ[2:0]),
    .ptr   (ptr),
    .gnt   (win),
    .valid (win_valid)
  );

  assign High = &Counter;
  assign Low  = ~|Counter;

  // In ARB look at the candidate winner (to register REJ alongside GNT);
  // in EXEC look at the registered winner, whose command is executed.
  assign sel_oh  = (state == ST_EXEC) ? GNT[2:0] : win;
  assign sel_idx = oh_to_idx(sel_oh);
  assign sel_cmd = cmd_e'(CMD[2*sel_idx +: 2]);
  assign sel_val = LD_VAL[WIDTH*sel_idx +: WIDTH];
  assign blocked = ((sel_cmd == CMD_UP) && High) || ((sel_cmd == CMD_DOWN) && Low);

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB: begin
        if (win_valid) state_nxt = ST_EXEC;
        else state_nxt = ST_ARB;
      end
      ST_EXEC: state_nxt = ST_ARB;
      default: state_nxt = ST_ARB;
    endcase
  end

  // Saturating counter update, only in EXEC
  always_comb begin
    counter_nxt = Counter;
    if (state == ST_EXEC) begin
      case (sel_cmd)
        CMD_UP: begin
          if (!High) counter_nxt = Counter + {{(WIDTH-1){1'b0}}, 1'b1};
          else counter_nxt = Counter;
        end
        CMD_DOWN: begin
          if (!Low) counter_nxt = Counter - {{(WIDTH-1){1'b0}}, 1'b1};
          else counter_nxt = Counter;
        end
        CMD_LOAD: counter_nxt = sel_val;
        default:  counter_nxt = Counter;
      endcase
    end else begin
      counter_nxt = Counter;
    end
  end

  // State, pointer, counter and grant/reject pulse registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= ST_ARB;
      ptr     <= 2'd0;
      Counter <= '0;
      GNT     <= '0;
      REJ     <= 1'b0;
    end else begin
      state   <= state_nxt;
      Counter <= counter_nxt;
      if ((state == ST_ARB) && win_valid) begin
        GNT <= win;
        REJ <= blocked;
        ptr <= next_ptr(oh_to_idx(win));
      end else begin
        GNT <= '0;
        REJ <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Directed self-checking bench for counter_access_arbiter.
module tb_counter_access_arbiter;

  logic        CLK;
  logic        RST;
  logic [2:0]  REQ;
  logic [5:0]  CMD;
  logic [14:0] LD_VAL;
  logic [2:0]  GNT;
  logic        REJ;
  logic [4:0]  Counter;
  logic        High;
  logic        Low;

  int checks;
  int failures;

  counter_access_arbiter #(.WIDTH(5), .N_REQ(3)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ     (REQ),
    .CMD     (CMD),
    .LD_VAL  (LD_VAL),
    .GNT     (GNT),
    .REJ     (REJ),
    .Counter (Counter),
    .High    (High),
    .Low     (Low)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input int r, input logic [1:0] c, input logic [4:0] v);
    REQ = 3'b000;
    REQ[r] = 1'b1;
    CMD[2*r +: 2] = c;
    LD_VAL[5*r +: 5] = v;
  endtask

  // One full transaction: grant cycle, then counter result cycle
  task automatic do_cmd(input string tag, input int r, input logic [1:0] c,
                        input logic [4:0] v, input logic exp_rej, input logic [4:0] exp_cnt);
    logic [2:0] exp_gnt;
    exp_gnt = 3'b000;
    exp_gnt[r] = 1'b1;
    issue(r, c, v);
    step();
    check({tag, "_gnt"}, {29'd0, GNT}, {29'd0, exp_gnt});
    check({tag, "_rej"}, {31'd0, REJ}, {31'd0, exp_rej});
    REQ = 3'b000;
    step();
    check({tag, "_cnt"}, {27'd0, Counter}, {27'd0, exp_cnt});
    check({tag, "_gnt0"}, {29'd0, GNT}, 32'd0);
    check({tag, "_rej0"}, {31'd0, REJ}, 32'd0);
  endtask

  initial begin
    logic [2:0] order [4];
    checks   = 0;
    failures = 0;
    RST    = 1'b0;
    REQ    = 3'b000;
    CMD    = 6'd0;
    LD_VAL = 15'd0;
    step();
    step();
    check("rst_cnt", {27'd0, Counter}, 32'd0);
    check("rst_gnt", {29'd0, GNT}, 32'd0);
    check("rst_rej", {31'd0, REJ}, 32'd0);
    check("rst_low", {31'd0, Low}, 32'd1);
    check("rst_high", {31'd0, High}, 32'd0);
    RST = 1'b1;
    step();
    check("idle_gnt", {29'd0, GNT}, 32'd0);

    // Load 7 via requester 0
    do_cmd("load7", 0, 2'b11, 5'd7, 1'b0, 5'd7);

    // Saturation at top and bottom via requester 1
    do_cmd("load31", 0, 2'b11, 5'd31, 1'b0, 5'd31);
    check("high31", {31'd0, High}, 32'd1);
    do_cmd("up_sat", 1, 2'b01, 5'd0, 1'b1, 5'd31);
    do_cmd("load0", 0, 2'b11, 5'd0, 1'b0, 5'd0);
    do_cmd("dn_sat", 1, 2'b10, 5'd0, 1'b1, 5'd0);
    do_cmd("load9", 1, 2'b11, 5'd9, 1'b0, 5'd9);
    do_cmd("nop", 1, 2'b00, 5'd0, 1'b0, 5'd9);

    // Round robin from PTR=0, Counter=0 after reset
    RST = 1'b0;
    step();
    RST = 1'b1;
    order[0] = 3'b001;
    order[1] = 3'b010;
    order[2] = 3'b100;
    order[3] = 3'b001;
    REQ = 3'b111;
    CMD = 6'b010101;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_gnt", {29'd0, GNT}, {29'd0, order[i]});
      if (i == 3) REQ = 3'b000;
      step();
      check("rr_cnt", {27'd0, Counter}, i + 1);
      check("rr_gnt0", {29'd0, GNT}, 32'd0);
    end

    // Requester 2 load 31, requester 0 up blocked; load 0, down blocked
    do_cmd("r2_load31", 2, 2'b11, 5'd31, 1'b0, 5'd31);
    do_cmd("r0_up_sat", 0, 2'b01, 5'd0, 1'b1, 5'd31);
    do_cmd("r2_load0", 2, 2'b11, 5'd0, 1'b0, 5'd0);
    do_cmd("r0_dn_sat", 0, 2'b10, 5'd0, 1'b1, 5'd0);

    // Requester 1 drops REQ during its EXEC cycle; command still executes
    do_cmd("load3", 0, 2'b11, 5'd3, 1'b0, 5'd3);
    issue(1, 2'b01, 5'd0);
    step();
    check("drop_gnt", {29'd0, GNT}, 32'b010);
    REQ = 3'b000;
    step();
    check("drop_cnt", {27'd0, Counter}, 32'd4);
    for (int i = 0; i < 3; i++) begin
      step();
      check("drop_nogrant", {29'd0, GNT}, 32'd0);
    end
    do_cmd("r2_down", 2, 2'b10, 5'd0, 1'b0, 5'd3);

    // Reset during EXEC of a LOAD 20 discards it
    issue(0, 2'b11, 5'd20);
    step();
    check("rstx_gnt", {29'd0, GNT}, 32'b001);
    RST = 1'b0;
    REQ = 3'b000;
    step();
    check("rstx_cnt", {27'd0, Counter}, 32'd0);
    check("rstx_gnt0", {29'd0, GNT}, 32'd0);
    check("rstx_low", {31'd0, Low}, 32'd1);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstx_nogrant", {29'd0, GNT}, 32'd0);
      check("rstx_hold", {27'd0, Counter}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
